// File: rtl/pixel_readout_pkg.sv
// Pixel readout sequencer shared types.
// State encoding and geometry helpers.
package pixel_readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_SETUP,
    S_SAMPLE,
    S_ROW_END,
    S_DONE
  } state_e;

  function automatic int f_clog2_min1(
    input int n
  );
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int f_groups(
    input int w,
    input int pbw
  );
    return w / pbw;
  endfunction

  function automatic int f_gsel_w(
    input int w,
    input int pbw
  );
    return f_clog2_min1(f_groups(w, pbw));
  endfunction

endpackage

// File: rtl/pixel_readout_sequencer_if.sv
// Array bus and output stream bundle.
// master = sequencer, slave = array/sink.
interface pixel_readout_sequencer_if #(
  parameter int HEIGHT = 2,
  parameter int GSW    = 1,
  parameter int DW     = 20
);
  logic [HEIGHT-1:0] ROW_SELECT;
  logic [GSW-1:0]    COLUMN_GROUP_SELECT;
  logic [DW-1:0]     PIXEL_BUS_IN;
  logic [DW-1:0]     DATA_OUT;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic              DATA_FIRST;
  logic              DATA_LAST;

  modport master (
    output ROW_SELECT,
    output COLUMN_GROUP_SELECT,
    input  PIXEL_BUS_IN,
    output DATA_OUT,
    output DATA_VALID,
    input  DATA_READY,
    output DATA_FIRST,
    output DATA_LAST
  );

  modport slave (
    input  ROW_SELECT,
    input  COLUMN_GROUP_SELECT,
    output PIXEL_BUS_IN,
    input  DATA_OUT,
    input  DATA_VALID,
    output DATA_READY,
    input  DATA_FIRST,
    input  DATA_LAST
  );
endinterface

// File: rtl/pixel_output_register.sv
// Valid/ready holding register for one beat.
// Holds data and markers until accepted.
module pixel_output_register #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_first,
  input  logic          i_last,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_first,
  output logic          o_last
);

  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_first;
  logic          r_last;

  // Capture on load, drop valid once accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_first <= i_first;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_first = r_first;
  assign o_last  = r_last;

endmodule

// File: rtl/pixel_readout_sequencer.sv
// Frame readout sequencer for a pixel array.
// Walks rows and column groups, streams beats.
module pixel_readout_sequencer
  import pixel_readout_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 10
) (
  input  logic SYSTEM_CLK,
  input  logic SYSTEM_RESET,
  input  logic READ_START,
  output logic BUSY,
  output logic OVERRUN,
  pixel_readout_sequencer_if.master bus
);

  localparam int GROUPS =
    f_groups(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int GSW =
    f_gsel_w(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int RW = f_clog2_min1(HEIGHT);
  localparam int DW =
    OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam logic [GSW-1:0] LP_GLAST =
    GSW'(GROUPS - 1);
  localparam logic [RW-1:0] LP_RLAST =
    RW'(HEIGHT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_start_q;
  logic [RW-1:0]     r_row;
  logic [RW-1:0]     w_row_nxt;
  logic [GSW-1:0]    r_group;
  logic [GSW-1:0]    w_group_nxt;
  logic [HEIGHT-1:0] r_row_sel;
  logic              r_overrun;
  logic              w_rise;
  logic              w_load;
  logic              w_first;
  logic              w_last;
  logic              w_valid;
  logic              w_drive;

  assign w_rise  = READ_START & ~r_start_q;
  assign w_load  = (r_state == S_SAMPLE) &&
                   (!w_valid || bus.DATA_READY);
  assign w_first = (r_row == '0) &&
                   (r_group == '0);
  assign w_last  = (r_row == LP_RLAST) &&
                   (r_group == LP_GLAST);
  assign w_drive = (w_state_nxt == S_ROW_SETUP) ||
                   (w_state_nxt == S_SAMPLE);

  // State, indices, row enable, edge history, sticky overrun
  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_group   <= '0;
      r_row_sel <= '0;
      r_start_q <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_group   <= w_group_nxt;
      r_start_q <= READ_START;
      r_row_sel <= w_drive ?
        (HEIGHT'(1) << w_row_nxt) : '0;
      if (w_rise && (r_state != S_IDLE))
        r_overrun <= 1'b1;
    end
  end

  // Next-state and index stepping
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_group_nxt = r_group;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_ROW_SETUP;
          w_row_nxt   = '0;
          w_group_nxt = '0;
        end
      end
      S_ROW_SETUP: w_state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        if (w_load) begin
          if (r_group == LP_GLAST) begin
            w_group_nxt = '0;
            w_state_nxt = S_ROW_END;
          end else begin
            w_group_nxt = r_group + GSW'(1);
          end
        end
      end
      S_ROW_END: begin
        if (r_row == LP_RLAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = r_row + RW'(1);
          w_state_nxt = S_ROW_SETUP;
        end
      end
      S_DONE: begin
        if (!w_valid || bus.DATA_READY)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  pixel_output_register #(
    .DW(DW)
  ) u_out (
    .clk     (SYSTEM_CLK),
    .rst_n   (SYSTEM_RESET),
    .i_load  (w_load),
    .i_data  (bus.PIXEL_BUS_IN),
    .i_first (w_first),
    .i_last  (w_last),
    .i_ready (bus.DATA_READY),
    .o_data  (bus.DATA_OUT),
    .o_valid (w_valid),
    .o_first (bus.DATA_FIRST),
    .o_last  (bus.DATA_LAST)
  );

  assign bus.DATA_VALID          = w_valid;
  assign bus.ROW_SELECT          = r_row_sel;
  assign bus.COLUMN_GROUP_SELECT = r_group;
  assign BUSY                    = (r_state != S_IDLE);
  assign OVERRUN                 = r_overrun;

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// Randomized bench for pixel_readout_sequencer.
// Frame-level model: expected beat queue per frame.
module tb_pixel_readout_sequencer;

  logic clk;
  logic rst_n;
  logic read_start;
  logic busy;
  logic overrun;

  pixel_readout_sequencer_if #(
    .HEIGHT(2), .GSW(1), .DW(20)
  ) bus ();

  pixel_readout_sequencer #(
    .WIDTH(4),
    .HEIGHT(2),
    .OUTPUT_BUS_PIXEL_WIDTH(2),
    .BIT_DEPTH(10)
  ) dut (
    .SYSTEM_CLK   (clk),
    .SYSTEM_RESET (rst_n),
    .READ_START   (read_start),
    .BUSY         (busy),
    .OVERRUN      (overrun),
    .bus          (bus)
  );

  typedef struct {
    logic [19:0] d;
    logic        f;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          beats_seen = 0;
  int          busy_cyc = 0;
  int          mode = 0;
  int          stall_left = 0;
  int          salt = 0;
  logic        prev_hold = 0;
  logic [19:0] hold_d;
  logic [1:0]  hold_fl;
  logic        hold_g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [19:0] beat_val(
    input int s, input int r, input int g
  );
    logic [19:0] v;
    v = '0;
    for (int p = 0; p < 2; p++)
      v[p*10 +: 10] = {4'(s), 2'(r), 2'(g), 2'(p)};
    return v;
  endfunction

  // Array model: selected row and group drive the bus
  always_comb begin
    bus.PIXEL_BUS_IN = '1;
    if (bus.ROW_SELECT == 2'b01)
      bus.PIXEL_BUS_IN =
        beat_val(salt, 0, int'(bus.COLUMN_GROUP_SELECT));
    else if (bus.ROW_SELECT == 2'b10)
      bus.PIXEL_BUS_IN =
        beat_val(salt, 1, int'(bus.COLUMN_GROUP_SELECT));
  end

  // Sink ready pattern
  always @(posedge clk) begin
    #1;
    if (mode == 2 && bus.DATA_VALID &&
        beats_seen == 1 && stall_left > 0) begin
      bus.DATA_READY = 1'b0;
      stall_left--;
    end else if (mode == 1) begin
      bus.DATA_READY = 1'($urandom_range(0, 1));
    end else begin
      bus.DATA_READY = 1'b1;
    end
  end

  // Monitor: order, markers, stability, row enable
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      chk("rowsel_onehot0",
          64'($countones(bus.ROW_SELECT) <= 1), 1);
      if (busy) busy_cyc++;
      if (prev_hold) begin
        chk("hold_data", bus.DATA_OUT, hold_d);
        chk("hold_marks",
            {bus.DATA_FIRST, bus.DATA_LAST}, hold_fl);
        chk("hold_group",
            bus.COLUMN_GROUP_SELECT, hold_g);
        chk("hold_valid", bus.DATA_VALID, 1);
      end
      prev_hold = bus.DATA_VALID && !bus.DATA_READY;
      hold_d  = bus.DATA_OUT;
      hold_fl = {bus.DATA_FIRST, bus.DATA_LAST};
      hold_g  = bus.COLUMN_GROUP_SELECT;
      if (bus.DATA_VALID && bus.DATA_READY) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", bus.DATA_OUT, e.d);
          chk("beat_first", bus.DATA_FIRST, e.f);
          chk("beat_last", bus.DATA_LAST, e.l);
        end
        beats_seen++;
      end
    end
  end

  task automatic push_frame();
    beat_t b;
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 2; g++) begin
        b.d = beat_val(salt, r, g);
        b.f = (r == 0 && g == 0);
        b.l = (r == 1 && g == 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic start(input int hold);
    @(posedge clk); #1;
    read_start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    read_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 ||
            bus.DATA_VALID) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_in_time", 64'(n < budget), 1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation hung");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    read_start     = 1'b0;
    bus.DATA_READY = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("rst_rowsel", bus.ROW_SELECT, 0);
    chk("rst_group", bus.COLUMN_GROUP_SELECT, 0);
    chk("rst_data", bus.DATA_OUT, 0);
    chk("rst_valid", bus.DATA_VALID, 0);
    chk("rst_first", bus.DATA_FIRST, 0);
    chk("rst_last", bus.DATA_LAST, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    cycles(3);

    // Basic frame, ready held high
    mode = 0; salt = 1;
    push_frame();
    busy_cyc = 0; beats_seen = 0;
    start(2);
    wait_idle(200);
    chk("busy_cycles", busy_cyc, 9);
    chk("beats_basic", beats_seen, 4);
    chk("no_overrun", overrun, 0);

    // Stall beat 2 for five cycles
    mode = 2; stall_left = 5; salt = 2;
    push_frame();
    beats_seen = 0;
    start(1);
    wait_idle(200);
    chk("beats_stall", beats_seen, 4);
    chk("stall_applied", stall_left, 0);

    // Random ready, several frames
    mode = 1;
    for (int k = 0; k < 6; k++) begin
      salt = int'($urandom_range(0, 15));
      push_frame();
      beats_seen = 0;
      start(int'($urandom_range(1, 3)));
      wait_idle(300);
      chk("beats_rand", beats_seen, 4);
      cycles(int'($urandom_range(0, 4)));
    end

    // Second edge during a frame
    mode = 0; salt = 9;
    push_frame();
    beats_seen = 0;
    start(2);
    cycles(1);
    read_start = 1'b1;
    cycles(1);
    read_start = 1'b0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    wait_idle(200);
    cycles(20);
    chk("beats_overrun", beats_seen, 4);
    chk("no_second_frame", busy, 0);
    chk("overrun_sticky", overrun, 1);

    // Reset during SAMPLE of row 1
    mode = 0; salt = 5;
    push_frame();
    beats_seen = 0;
    start(1);
    n = 0;
    while (bus.ROW_SELECT != 2'b10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_row1", 64'(n < 100), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rowsel", bus.ROW_SELECT, 0);
    chk("arst_group", bus.COLUMN_GROUP_SELECT, 0);
    chk("arst_data", bus.DATA_OUT, 0);
    chk("arst_valid", bus.DATA_VALID, 0);
    chk("arst_marks",
        {bus.DATA_FIRST, bus.DATA_LAST}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    exp_q.delete();
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    beats_seen = 0;
    cycles(20);
    chk("no_beats_after_rst", beats_seen, 0);
    chk("idle_after_rst", busy, 0);

    // READ_START held high for 50 cycles
    mode = 0; salt = 12;
    push_frame();
    beats_seen = 0;
    start(50);
    wait_idle(200);
    cycles(10);
    chk("beats_held", beats_seen, 4);
    chk("queue_empty_held", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_readout_sequencer.md
PIXEL_READOUT_SEQUENCER -- requirements
Module: pixel_readout_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning pixel columns.
REQ-002 SHALL have parameter HEIGHT, default 2, meaning pixel rows.
REQ-003 SHALL have parameter OUTPUT_BUS_PIXEL_WIDTH, default 2, meaning pixels per bus beat; WIDTH is a multiple of it; GROUPS = WIDTH/OUTPUT_BUS_PIXEL_WIDTH.
REQ-004 SHALL have parameter BIT_DEPTH, default 10, meaning bits per pixel.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port: SYSTEM_CLK  in  1  sole clock, all logic on posedge.
REQ-007 Port: SYSTEM_RESET  in  1  asynchronous, active-low reset.
REQ-008 Port: READ_START  in  1  read-phase level from the pixel state machine; a rising edge starts one frame.
REQ-009 Port: ROW_SELECT  out  HEIGHT  one-hot row enable onto the column bus.
REQ-010 Port: COLUMN_GROUP_SELECT  out  max(1,ceil(log2(GROUPS)))  column group driven onto PIXEL_BUS_IN.
REQ-011 Port: PIXEL_BUS_IN  in  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  pixel data from the array.
REQ-012 Port: DATA_OUT  out  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  captured beat.
REQ-013 Port: DATA_VALID  out  1  DATA_OUT holds an unaccepted beat.
REQ-014 Port: DATA_READY  in  1  downstream accepts the beat when DATA_VALID&&DATA_READY at posedge.
REQ-015 Port: DATA_FIRST / DATA_LAST  out  1 each  beat is first (row 0, group 0) / last (row HEIGHT-1, group GROUPS-1) of the frame.
REQ-016 Port: BUSY  out  1  high in every state except IDLE.
REQ-017 Port: OVERRUN  out  1  sticky: READ_START rising edge seen while BUSY.

Function
REQ-018 SHALL detect the READ_START rising edge with a one-flop history register sampled on posedge.
REQ-019 SHALL implement states IDLE, ROW_SETUP, SAMPLE, ROW_END, DONE.
REQ-020 IDLE -> ROW_SETUP on a detected edge; row index 0, group 0, ROW_SELECT = one-hot(row) registered on that posedge.
REQ-021 ROW_SETUP lasts exactly 1 cycle (bus settle), then SAMPLE.
REQ-022 In SAMPLE, the output register loads PIXEL_BUS_IN, DATA_FIRST, DATA_LAST when !DATA_VALID || DATA_READY; otherwise state, group and DATA_OUT hold.
REQ-023 Each load increments the group; the load at group GROUPS-1 moves to ROW_END.
REQ-024 ROW_END lasts 1 cycle with ROW_SELECT all-zero; then ROW_SETUP for row+1, or DONE after row HEIGHT-1.
REQ-025 DONE waits until the last beat is accepted (DATA_VALID low, or high with DATA_READY), then goes to IDLE.
REQ-026 With DATA_READY held high, BUSY SHALL stay high for exactly (2+GROUPS)*HEIGHT+1 cycles.
REQ-027 Beat order SHALL be row-major, row 0 first, group 0 first within a row; no beat is dropped or duplicated under any DATA_READY pattern.
REQ-028 DATA_OUT, DATA_FIRST and DATA_LAST SHALL be stable while DATA_VALID is high and DATA_READY is low.
REQ-029 A READ_START edge while BUSY SHALL be ignored and SHALL set OVERRUN; OVERRUN clears only on reset.
REQ-030 READ_START held high after a frame SHALL NOT start a second frame.

Reset
REQ-031 Reset SHALL force IDLE, ROW_SELECT=0, COLUMN_GROUP_SELECT=0, DATA_OUT=0, DATA_VALID=0, DATA_FIRST=0, DATA_LAST=0, BUSY=0, OVERRUN=0, edge history=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); after release, no frame starts until a new READ_START rising edge.

Structure
REQ-033 Package pixel_readout_pkg SHALL hold the state enum and the GROUPS and group-select-width constant functions.
REQ-034 The valid/ready holding register (data, DATA_FIRST, DATA_LAST) SHALL be one sub-module, pixel_output_register.

Verification (bench: WIDTH=4, HEIGHT=2, OUTPUT_BUS_PIXEL_WIDTH=2, BIT_DEPTH=10, array model drives {row,group} pattern)
REQ-035 Edge on READ_START, DATA_READY=1 -> BUSY high for 9 cycles; 4 beats in order (0,0),(0,1),(1,0),(1,1); DATA_FIRST on beat 1 only, DATA_LAST on beat 4 only.
REQ-036 DATA_READY low for 5 cycles on beat 2 -> DATA_OUT and group select hold; all 4 beats delivered once, in order.
REQ-037 Second READ_START edge during frame -> OVERRUN=1, frame completes normally with 4 beats, no second frame.
REQ-038 SYSTEM_RESET low during SAMPLE of row 1 -> all outputs at reset values in the same cycle; no beats after release until a new edge.
REQ-039 READ_START held high for 50 cycles -> exactly one frame; ROW_SELECT one-hot or zero at every cycle.
